// File: rtl/multi_channel_counter_if.sv
// rtl/multi_channel_counter_if.sv - control, configuration and status bundle for the counter bank
interface multi_channel_counter_if #(
  parameter int COUNTER_WIDTH = 4,
  parameter int NUM_CHANNELS  = 4
);
  logic [NUM_CHANNELS-1:0]               clr_i;
  logic [NUM_CHANNELS-1:0]               ld_i;
  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] ld_value_i;
  logic [NUM_CHANNELS-1:0]               en_i;
  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] limit_i;
  logic [NUM_CHANNELS-1:0]               mode_i;
  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] count_num_o;
  logic [NUM_CHANNELS-1:0]               wrap_o;
  logic [NUM_CHANNELS-1:0]               sat_o;
  logic                                  any_wrap_o;

  modport master (
    output clr_i, ld_i, ld_value_i, en_i, limit_i, mode_i,
    input  count_num_o, wrap_o, sat_o, any_wrap_o
  );

  modport slave (
    input  clr_i, ld_i, ld_value_i, en_i, limit_i, mode_i,
    output count_num_o, wrap_o, sat_o, any_wrap_o
  );
endinterface

// File: rtl/multi_channel_counter.sv
// rtl/multi_channel_counter.sv - bank of independent clear/load/limit counters with wrap or saturate
module multi_channel_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  multi_channel_counter_if.slave  cnt_if
);

  typedef enum logic {
    ST_COUNTING = 1'b0,
    ST_TERMINAL = 1'b1
  } chan_state_e;

  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] count_q, count_d;
  logic [NUM_CHANNELS-1:0]               wrap_q, wrap_d;
  logic                                  any_wrap_q, any_wrap_d;
  logic [NUM_CHANNELS-1:0]               sat_vec;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q    <= '0;
      wrap_q     <= '0;
      any_wrap_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      any_wrap_q <= any_wrap_d;
    end
  end

  // The channel state is derived from the live limit, so a limit change moves it immediately.
  always_comb begin
    count_d = count_q;
    wrap_d  = '0;
    sat_vec = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      logic [COUNTER_WIDTH-1:0] cur;
      logic [COUNTER_WIDTH-1:0] lim;
      chan_state_e              state;
      cur   = count_q[c*COUNTER_WIDTH +: COUNTER_WIDTH];
      lim   = cnt_if.limit_i[c*COUNTER_WIDTH +: COUNTER_WIDTH];
      state = (cur >= lim) ? ST_TERMINAL : ST_COUNTING;
      sat_vec[c] = cnt_if.mode_i[c] && (state == ST_TERMINAL);
      if (cnt_if.clr_i[c]) begin
        count_d[c*COUNTER_WIDTH +: COUNTER_WIDTH] = '0;
      end else if (cnt_if.ld_i[c]) begin
        count_d[c*COUNTER_WIDTH +: COUNTER_WIDTH] =
          cnt_if.ld_value_i[c*COUNTER_WIDTH +: COUNTER_WIDTH];
      end else if (cnt_if.en_i[c]) begin
        unique case (state)
          ST_COUNTING: count_d[c*COUNTER_WIDTH +: COUNTER_WIDTH] = cur + COUNTER_WIDTH'(1);
          ST_TERMINAL: begin
            if (!cnt_if.mode_i[c]) begin
              count_d[c*COUNTER_WIDTH +: COUNTER_WIDTH] = '0;
              wrap_d[c] = 1'b1;
            end
          end
        endcase
      end
    end
    any_wrap_d = |wrap_d;
  end

  assign cnt_if.count_num_o = count_q;
  assign cnt_if.wrap_o      = wrap_q;
  assign cnt_if.any_wrap_o  = any_wrap_q;
  assign cnt_if.sat_o       = sat_vec;

endmodule

// File: tb/tb_multi_channel_counter.sv
// tb/tb_multi_channel_counter.sv - scoreboard bench for multi_channel_counter
module tb_multi_channel_counter;

  localparam int W = 4;
  localparam int N = 4;

  typedef struct {
    string      name;
    int         cyc;
    int         ch;
    logic [15:0] cnt;
    logic [3:0]  wrap;
    logic [3:0]  sat;
    logic        any;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  multi_channel_counter_if #(.COUNTER_WIDTH(W), .NUM_CHANNELS(N)) bus ();

  multi_channel_counter #(.COUNTER_WIDTH(W), .NUM_CHANNELS(N)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .cnt_if  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Channel 0 under test; other channels held in clear with a limit that keeps sat low.
  task automatic drive0(input logic clr0, input logic ld0, input logic [3:0] ldv0,
                        input logic en0, input logic [3:0] lim0, input logic mode0);
    @(negedge clk);
    bus.clr_i      = {3'b111, clr0};
    bus.ld_i       = {3'b000, ld0};
    bus.ld_value_i = {12'h000, ldv0};
    bus.en_i       = {3'b000, en0};
    bus.limit_i    = {12'hFFF, lim0};
    bus.mode_i     = {3'b000, mode0};
  endtask

  task automatic expect0(input string nm, input logic [3:0] cnt, input logic wrap, input logic sat);
    exp_t e;
    e.name = nm; e.cyc = cyc + 1; e.ch = 0;
    e.cnt = {12'h000, cnt}; e.wrap = {3'b000, wrap}; e.sat = {3'b000, sat}; e.any = wrap;
    sb_q.push_back(e);
  endtask

  // Monitor: compares every registered output sample against the scoreboard entry due this cycle.
  initial begin
    exp_t e;
    logic [24:0] act, exp;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          checks++; errors++;
          $display("FAIL %s: sample missed, due cycle %0d now %0d", e.name, e.cyc, cyc);
        end else if (e.ch >= 0) begin
          act = {18'b0, bus.count_num_o[e.ch*W +: W], bus.wrap_o[e.ch], bus.sat_o[e.ch], bus.any_wrap_o};
          exp = {18'b0, e.cnt[3:0], e.wrap[0], e.sat[0], e.any};
          check(e.name, act, exp);
        end else begin
          act = {bus.count_num_o, bus.wrap_o, bus.sat_o, bus.any_wrap_o};
          exp = {e.cnt, e.wrap, e.sat, e.any};
          check(e.name, act, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int wrap_cnt[14] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2};
    int sat_cnt[6]   = '{1, 2, 3, 3, 3, 3};
    int m[N];
    int lims[N]      = '{0, 2, 7, 15};
    exp_t e;
    logic [3:0] w, v;

    // Reset with arbitrary inputs: outputs must be zero without any clock edge.
    bus.clr_i = 4'($urandom); bus.ld_i = 4'($urandom); bus.ld_value_i = 16'($urandom);
    bus.en_i = 4'($urandom); bus.limit_i = 16'hFFFF; bus.mode_i = 4'($urandom);
    #3;
    check("reset_outputs", {bus.count_num_o, bus.wrap_o, 4'b0, bus.any_wrap_o}, 25'd0);
    bus.limit_i = 16'h0000; bus.mode_i = 4'hF;
    #1;
    check("reset_sat_limit0", {21'b0, bus.sat_o}, {21'b0, 4'hF});
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap mode, limit 5
    drive0(1, 0, 0, 0, 4'd15, 0); expect0("wrap_clr", 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      drive0(0, 0, 0, 1, 4'd5, 0);
      expect0($sformatf("wrap_l5_%0d", i), 4'(wrap_cnt[i]), wrap_cnt[i] == 0, 0);
    end

    // Saturate mode, limit 3
    drive0(1, 0, 0, 0, 4'd15, 0); expect0("sat_clr", 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive0(0, 0, 0, 1, 4'd3, 1);
      expect0($sformatf("sat_l3_%0d", i), 4'(sat_cnt[i]), 0, sat_cnt[i] == 3);
    end

    // Priority, out-of-range load, limit increase
    drive0(1, 1, 4'd9, 1, 4'd5, 0); expect0("prio_clr", 0, 0, 0);
    drive0(0, 1, 4'd9, 1, 4'd5, 0); expect0("prio_ld", 9, 0, 0);
    drive0(0, 0, 0, 1, 4'd5, 0);    expect0("prio_wrap", 0, 1, 0);
    drive0(0, 0, 0, 1, 4'd5, 0);    expect0("prio_after", 1, 0, 0);
    drive0(0, 1, 4'd9, 0, 4'd5, 1); expect0("ld_over_sat", 9, 0, 1);
    drive0(0, 0, 0, 1, 4'd5, 1);    expect0("sat_hold", 9, 0, 1);
    drive0(0, 0, 0, 0, 4'd12, 1);   expect0("limit_raise", 9, 0, 0);

    // Full range, limit all-ones
    drive0(1, 0, 0, 0, 4'd15, 0); expect0("full_clr", 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      drive0(0, 0, 0, 1, 4'd15, 0);
      expect0($sformatf("full_%0d", i), 4'(i % 16), i == 16, 0);
    end

    // Limit 0: continuous wrap pulses
    drive0(1, 0, 0, 0, 4'd15, 0); expect0("l0_clr", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive0(0, 0, 0, 1, 4'd0, 0);
      expect0($sformatf("l0_wrap_%0d", i), 0, 1, 0);
    end
    drive0(0, 0, 0, 0, 4'd0, 0); expect0("l0_stop", 0, 0, 0);
    drive0(0, 0, 0, 0, 4'd0, 1); expect0("l0_sat", 0, 0, 1);

    // Independence: all channels, reference model
    @(negedge clk);
    bus.clr_i = 4'hF; bus.ld_i = 4'h0; bus.en_i = 4'h0; bus.mode_i = 4'h0;
    bus.limit_i = {4'd15, 4'd7, 4'd2, 4'd0};
    for (int c = 0; c < N; c++) m[c] = 0;
    e.name = "ind_clr"; e.cyc = cyc + 1; e.ch = -1; e.cnt = 16'h0; e.wrap = 4'h0; e.sat = 4'h0; e.any = 1'b0;
    sb_q.push_back(e);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      bus.clr_i = 4'h0;
      w = 4'h0;
      for (int c = 0; c < N; c++) begin
        bus.en_i[c] = ($urandom_range(0, 3) < c + 1);
        bus.ld_i[c] = ($urandom_range(0, 15) == 0);
        v = 4'($urandom_range(0, 15));
        bus.ld_value_i[c*W +: W] = v;
        if (bus.ld_i[c]) m[c] = int'(v);
        else if (bus.en_i[c]) begin
          if (m[c] >= lims[c]) begin m[c] = 0; w[c] = 1'b1; end
          else m[c] = m[c] + 1;
        end
      end
      e.name = $sformatf("ind_%0d", n); e.cyc = cyc + 1; e.ch = -1;
      e.cnt = {4'(m[3]), 4'(m[2]), 4'(m[1]), 4'(m[0])};
      e.wrap = w; e.sat = 4'h0; e.any = |w;
      sb_q.push_back(e);
    end

    // Asynchronous reset mid-cycle, then first update after release
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid", {bus.count_num_o, bus.wrap_o, 4'b0, bus.any_wrap_o}, 25'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.clr_i = 4'hE; bus.ld_i = 4'h0; bus.en_i = 4'h1; bus.mode_i = 4'h0;
    bus.limit_i = {12'hFFF, 4'd5};
    expect0("post_reset_first", 1, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++; errors++;
      $display("FAIL %s: expectation never compared", e.name);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
